multdiv_ctrl: RTL
=================

// Module: multdiv_ctrl
// PURPOSE
//  Sequencer for the shared multi-cycle multiply and divide datapaths.
//  - Accepts one-cycle start pulses and latches both operands.
//  - Drives the iteration count the datapaths use to select load versus iterate.
//  - Captures the result and overflow at the end of the operation and issues a one-cycle ready pulse.
//  - Sits between the pipeline's execute stage (stall logic uses busy) and the mult/div datapaths.
// PARAMETERS
//  MULT_CYCLES  16  count value at which the mult result is final (captured)
//  DIV_CYCLES   32  count value at which the div result is final (captured)
// PORTS
//  clk             in   1   system clock, rising edge
//  reset_n         in   1   synchronous, active-low reset
//  ctrl_MULT       in   1   start-multiply pulse, sampled on clk
//  ctrl_DIV        in   1   start-divide pulse, sampled on clk
//  data_operandA   in   32  multiplicand / dividend (signed)
//  data_operandB   in   32  multiplier / divisor (signed)
//  mult_result     in   32  from mult datapath
//  mult_ovf        in   1   from mult datapath
//  div_result      in   32  from div datapath (0 on overflow)
//  div_ovf         in   1   from div datapath (div-by-0, MIN/-1)
//  op_a            out  32  latched operand A to both datapaths
//  op_b            out  32  latched operand B to both datapaths
//  count           out  6   iteration count to active datapath
//  mult_en         out  1   1 while mult is the active op
//  div_en          out  1   1 while div is the active op
//  busy            out  1   1 in RUN
//  data_result     out  32  registered result
//  data_exception  out  1   registered overflow/exception
//  data_resultRDY  out  1   one-cycle pulse: result/exception valid
// BEHAVIOUR
//  Reset (reset_n=0 at edge)
//  - state=IDLE; all outputs 0, including count, op_a/op_b, result, exception.
//  - Reset wins over any simultaneous ctrl pulse.
//  - Mid-operation reset aborts the op; no RDY pulse is issued for it.
//  States
//  - IDLE: no op active.
//  - RUN: op in progress.
//  - DONE: one-cycle ready state.
//  Start
//  - Exactly one of ctrl_MULT/ctrl_DIV high at an edge, in any state:
//    - latch op_a/op_b; count:=0; set mult_en or div_en (other cleared); state:=RUN.
//    - A start during RUN aborts the current op and restarts; the old result is discarded.
//    - A start during DONE is accepted; RDY is still 1 for that DONE cycle.
//  - Both ctrl_MULT and ctrl_DIV high at an edge:
//    - no op starts; mult_en=div_en=0; data_result:=0; data_exception:=1; state:=DONE.
//  RUN
//  - count increments by 1 per edge, from 0 to LAT (LAT = MULT_CYCLES or DIV_CYCLES).
//  - At the edge where count==LAT:
//    - data_result := active result; data_exception := active ovf.
//    - count holds LAT; state:=DONE.
//  - No wrap-around: count never exceeds LAT.
//  DONE
//  - data_resultRDY=1 for exactly this cycle; busy=0.
//  - Next edge: state:=IDLE; mult_en/div_en:=0; count:=0.
//  IDLE
//  - data_result/data_exception hold their last values until the next capture or reset.
//  Latency
//  - Start edge E0; capture at edge E(LAT+1); data_resultRDY high in the cycle after E(LAT+1).
//  - DIV default: RDY in cycle 34 after the start edge. MULT default: RDY in cycle 18.
//  - op_a/op_b are stable for the whole of RUN; the datapaths see count==0 in the first RUN cycle.
//  busy = (state==RUN); data_resultRDY = (state==DONE). Both are registered-state decodes.
// TESTING
//  1. DIV 100/7 -> busy 1 for 33 cycles; RDY single pulse; result=14, exception=0.
//  2. DIV -100/7 and 100/-7 -> result=0xFFFFFFF2 (-14), exception=0; DIV 5/0 -> result=0, exception=1.
//  3. DIV 0x80000000 / 0xFFFFFFFF -> result=0, exception=1; MULT 6*-7 -> result=-42, RDY after 18 cycles.
//  4. ctrl_MULT and ctrl_DIV high together -> next cycle RDY=1, exception=1, result=0; busy never set.
//  5. DIV 100/7 started, then DIV 9/3 at count=10 -> exactly one RDY, result=3, 34 cycles after the second start.
//  6. reset_n=0 for one edge at count=20 -> all outputs 0, no RDY; a new DIV 8/2 then gives result=4.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide datapaths: latches operands,
// drives the iteration count, captures result/overflow and pulses data_resultRDY.
module multdiv_ctrl #(
  parameter int MULT_CYCLES = 16,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [31:0] mult_result,
  input  logic        mult_ovf,
  input  logic [31:0] div_result,
  input  logic        div_ovf,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [5:0]  count,
  output logic        mult_en,
  output logic        div_en,
  output logic        busy,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] MULT_LAT = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_LAT  = 6'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [5:0]  count_q, count_d;
  logic        mult_en_q, mult_en_d;
  logic        div_en_q, div_en_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic        start_one;
  logic        start_both;
  logic [5:0]  lat;

  assign start_one  = ctrl_MULT ^ ctrl_DIV;
  assign start_both = ctrl_MULT & ctrl_DIV;
  assign lat        = mult_en_q ? MULT_LAT : DIV_LAT;

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    count_d   = count_q;
    mult_en_d = mult_en_q;
    div_en_d  = div_en_q;
    result_d  = result_q;
    exc_d     = exc_q;
    // A start in any state wins, aborting whatever was in flight.
    if (start_one) begin
      op_a_d    = data_operandA;
      op_b_d    = data_operandB;
      count_d   = 6'd0;
      mult_en_d = ctrl_MULT;
      div_en_d  = ctrl_DIV;
      state_d   = RUN;
    end else if (start_both) begin
      mult_en_d = 1'b0;
      div_en_d  = 1'b0;
      count_d   = 6'd0;
      result_d  = 32'd0;
      exc_d     = 1'b1;
      state_d   = DONE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (count_q == lat) begin
            result_d = mult_en_q ? mult_result : div_result;
            exc_d    = mult_en_q ? mult_ovf : div_ovf;
            state_d  = DONE;
          end else begin
            count_d = count_q + 6'd1;
          end
        end
        DONE: begin
          mult_en_d = 1'b0;
          div_en_d  = 1'b0;
          count_d   = 6'd0;
          state_d   = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      count_q   <= 6'd0;
      mult_en_q <= 1'b0;
      div_en_q  <= 1'b0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      count_q   <= count_d;
      mult_en_q <= mult_en_d;
      div_en_q  <= div_en_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign count          = count_q;
  assign mult_en        = mult_en_q;
  assign div_en         = div_en_q;
  assign busy           = (state_q == RUN);
  assign data_resultRDY = (state_q == DONE);
  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule
